// File: rtl/piso_tx.sv
// Parallel-in, serial-out transmitter with a one-entry holding register so
// consecutive words leave the serial line with no idle gap.
module piso_tx #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             enable,
  output logic             data_out,
  output logic             frame,
  output logic             done,
  output logic             busy
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] sreg_shifted;

  assign accept   = load_valid && !hold_full_q;
  assign last_bit = (state_q == SHIFT) && enable && (cnt_q == CNT_LAST);

  // Shift toward the output end, zero fill behind.
  always_comb begin
    if (MSB_FIRST) begin
      sreg_shifted = {sreg_q[WIDTH-2:0], 1'b0};
    end else begin
      sreg_shifted = {1'b0, sreg_q[WIDTH-1:1]};
    end
  end

  // Next-state logic for the shifter, holding register and counter.
  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          sreg_d  = load_data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          done_d = 1'b1;
          cnt_d  = '0;
          if (hold_full_q) begin
            sreg_d      = hold_q;
            hold_full_d = 1'b0;
          end else if (accept) begin
            sreg_d = load_data;
          end else begin
            sreg_d  = '0;
            state_d = IDLE;
          end
        end else begin
          if (enable) begin
            sreg_d = sreg_shifted;
            cnt_d  = cnt_q + CNT_W'(1);
          end
          // Word arriving mid-frame parks in the holding register.
          if (accept) begin
            hold_d      = load_data;
            hold_full_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        sreg_d  = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
    end
  end

  // sreg is cleared whenever the block leaves SHIFT, so the output bit is 0 outside a frame.
  assign data_out   = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
  assign frame      = (state_q == SHIFT);
  assign done       = done_q;
  assign busy       = (state_q == SHIFT) || hold_full_q;
  assign load_ready = !hold_full_q;

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: a 4-bit MSB-first instance and an 8-bit LSB-first instance.
module tb_piso_tx;

  logic       clk;
  logic       reset;

  logic [3:0] a_load_data;
  logic       a_load_valid, a_load_ready, a_enable;
  logic       a_data_out, a_frame, a_done, a_busy;

  logic [7:0] b_load_data;
  logic       b_load_valid, b_load_ready, b_enable;
  logic       b_data_out, b_frame, b_done, b_busy;

  int total;
  int bad;

  piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_a (
    .clk        (clk),
    .reset      (reset),
    .load_data  (a_load_data),
    .load_valid (a_load_valid),
    .load_ready (a_load_ready),
    .enable     (a_enable),
    .data_out   (a_data_out),
    .frame      (a_frame),
    .done       (a_done),
    .busy       (a_busy)
  );

  piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_b (
    .clk        (clk),
    .reset      (reset),
    .load_data  (b_load_data),
    .load_valid (b_load_valid),
    .load_ready (b_load_ready),
    .enable     (b_enable),
    .data_out   (b_data_out),
    .frame      (b_frame),
    .done       (b_done),
    .busy       (b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; outputs are examined and inputs changed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0]  w4;
  logic [7:0]  bits8;
  logic [5:0]  en_pat;
  logic [5:0]  exp_pat;
  logic [7:0]  exp_b2b;

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    a_load_data = '0; a_load_valid = 1'b0; a_enable = 1'b0;
    b_load_data = '0; b_load_valid = 1'b0; b_enable = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_data_out", 32'(a_data_out), 32'd0);
    check("rst_frame", 32'(a_frame), 32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_load_ready", 32'(a_load_ready), 32'd1);
    check("rst_done", 32'(a_done), 32'd0);
    reset = 1'b0;

    // Idle with enable high does nothing
    a_enable = 1'b1;
    tick();
    check("idle_frame", 32'(a_frame), 32'd0);
    check("idle_data", 32'(a_data_out), 32'd0);

    // Test 1: 1011 MSB first, enable held high
    w4 = 4'b1011;
    a_load_data = w4; a_load_valid = 1'b1;
    tick();
    a_load_valid = 1'b0;
    a_load_data  = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      check("t1_data", 32'(a_data_out), 32'(w4[3-i]));
      check("t1_frame", 32'(a_frame), 32'd1);
      check("t1_done", 32'(a_done), 32'd0);
      tick();
    end
    check("t1_done_pulse", 32'(a_done), 32'd1);
    check("t1_frame_end", 32'(a_frame), 32'd0);
    check("t1_ready_end", 32'(a_load_ready), 32'd1);
    check("t1_data_end", 32'(a_data_out), 32'd0);
    tick();
    check("t1_done_clear", 32'(a_done), 32'd0);

    // Test 2: enable pattern 1,0,0,1,1,1 (index 0 first)
    en_pat  = 6'b111001;
    exp_pat = 6'b110001;
    a_load_data = 4'b1011; a_load_valid = 1'b1;
    tick();
    a_load_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      a_enable = en_pat[i];
      check("t2_data", 32'(a_data_out), 32'(exp_pat[i]));
      check("t2_frame", 32'(a_frame), 32'd1);
      check("t2_done", 32'(a_done), 32'd0);
      tick();
    end
    check("t2_done_pulse", 32'(a_done), 32'd1);
    check("t2_frame_end", 32'(a_frame), 32'd0);
    tick();

    // Test 3: back-to-back 1100 then 0110
    exp_b2b = 8'b1100_0110;
    a_enable = 1'b1;
    a_load_data = 4'b1100; a_load_valid = 1'b1;
    tick();
    check("t3_data_c1", 32'(a_data_out), 32'(exp_b2b[7]));
    check("t3_ready_c1", 32'(a_load_ready), 32'd1);
    a_load_data = 4'b0110; a_load_valid = 1'b1;
    tick();
    a_load_valid = 1'b0;
    for (int c = 2; c <= 8; c++) begin
      check("t3_data", 32'(a_data_out), 32'(exp_b2b[8-c]));
      check("t3_frame", 32'(a_frame), 32'd1);
      check("t3_busy", 32'(a_busy), 32'd1);
      check("t3_done", 32'(a_done), (c == 5) ? 32'd1 : 32'd0);
      check("t3_ready", 32'(a_load_ready), (c >= 2 && c <= 4) ? 32'd0 : 32'd1);
      tick();
    end
    check("t3_done2", 32'(a_done), 32'd1);
    check("t3_frame_end", 32'(a_frame), 32'd0);
    tick();

    // Test 4: bypass on the last-bit edge, hold stays empty
    a_load_data = 4'b1001; a_load_valid = 1'b1;
    tick();
    a_load_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      check("t4_w1_data", 32'(a_data_out), 32'(c == 1 || c == 4));
      check("t4_w1_ready", 32'(a_load_ready), 32'd1);
      if (c == 4) begin
        a_load_data = 4'b0101; a_load_valid = 1'b1;
      end
      tick();
    end
    a_load_valid = 1'b0;
    w4 = 4'b0101;
    for (int c = 5; c <= 8; c++) begin
      check("t4_w2_data", 32'(a_data_out), 32'(w4[8-c]));
      check("t4_w2_frame", 32'(a_frame), 32'd1);
      check("t4_w2_ready", 32'(a_load_ready), 32'd1);
      check("t4_w2_done", 32'(a_done), (c == 5) ? 32'd1 : 32'd0);
      tick();
    end
    check("t4_done2", 32'(a_done), 32'd1);
    check("t4_frame_end", 32'(a_frame), 32'd0);
    tick();

    // Test 5: reset after two bits of 1111 with 1010 held
    a_load_data = 4'b1111; a_load_valid = 1'b1;
    tick();
    a_load_data = 4'b1010; a_load_valid = 1'b1;
    tick();
    a_load_valid = 1'b0;
    check("t5_held", 32'(a_load_ready), 32'd0);
    reset = 1'b1;
    tick();
    check("t5_rst_data", 32'(a_data_out), 32'd0);
    check("t5_rst_frame", 32'(a_frame), 32'd0);
    check("t5_rst_busy", 32'(a_busy), 32'd0);
    check("t5_rst_ready", 32'(a_load_ready), 32'd1);
    check("t5_rst_done", 32'(a_done), 32'd0);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      check("t5_post_frame", 32'(a_frame), 32'd0);
      check("t5_post_done", 32'(a_done), 32'd0);
      check("t5_post_data", 32'(a_data_out), 32'd0);
    end

    // Test 6: WIDTH=8 LSB first, 8'hA5
    bits8 = 8'hA5;
    b_enable = 1'b1;
    b_load_data = bits8; b_load_valid = 1'b1;
    tick();
    b_load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("t6_data", 32'(b_data_out), 32'(bits8[i]));
      check("t6_frame", 32'(b_frame), 32'd1);
      check("t6_done", 32'(b_done), 32'd0);
      tick();
    end
    check("t6_done_pulse", 32'(b_done), 32'd1);
    check("t6_frame_end", 32'(b_frame), 32'd0);
    check("t6_busy_end", 32'(b_busy), 32'd0);
    tick();
    check("t6_done_clear", 32'(b_done), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/piso_tx.md
Name: piso_tx

Overview:
- Parallel-in, serial-out transmitter. Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per enabled clock on data_out, with a frame qualifier.
- Drives the serial data_in / enable pair of the team's serial shift-register receivers.
- A one-entry holding register allows back-to-back words with no idle gap on the serial line.

Parameters:
- WIDTH, 4: word width in bits; legal range is 2 or more.
- MSB_FIRST, 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- load_data  input  WIDTH  parallel word to transmit.
- load_valid  input  1  load_data is valid this cycle.
- load_ready  output  1  block can accept a word this cycle.
- enable  input  1  shift strobe; one serial bit is consumed per clock with enable=1.
- data_out  output  1  current serial bit.
- frame  output  1  high while data_out carries a valid bit of a word.
- done  output  1  one-cycle pulse after the last bit of a word is consumed.
- busy  output  1  high when the state is SHIFT or the holding register is full.

Behaviour:
- Storage:
  - sreg[WIDTH-1:0], the shift register.
  - hold[WIDTH-1:0] plus hold_full, the holding register.
  - cnt, a bit counter of ceil(log2(WIDTH)) bits.
  - state, either IDLE or SHIFT.
- Reset:
  - Register values: state=IDLE, sreg=0, hold_full=0, cnt=0, done=0.
  - Outputs during and after reset: data_out=0, frame=0, busy=0, load_ready=1.
  - Reset mid-word aborts the word and discards the held word; no done pulse is generated.
- Handshake:
  - load_ready = !hold_full (combinational).
  - A word is accepted on a clock edge where load_valid && load_ready.
  - load_data is sampled only on acceptance and is ignored otherwise.
- IDLE:
  - On acceptance: sreg<=load_data, cnt<=0, state<=SHIFT.
  - enable is ignored in IDLE; sreg stays 0.
- SHIFT:
  - frame=1.
  - data_out = sreg[WIDTH-1] if MSB_FIRST, else sreg[0].
  - enable=0: sreg and cnt hold; data_out stays stable indefinitely.
  - enable=1 with cnt<WIDTH-1: shift toward the output end (MSB_FIRST: left; else right), fill with 0, cnt<=cnt+1.
  - enable=1 with cnt==WIDTH-1: this is the last bit. done<=1 the next cycle, then:
    - If hold_full: sreg<=hold, hold_full<=0, cnt<=0, stay in SHIFT (no gap).
    - Else if a word is accepted this same edge: sreg<=load_data, cnt<=0, stay in SHIFT (bypasses hold).
    - Else: sreg<=0, state<=IDLE.
  - Acceptance in SHIFT when the last-bit case does not apply: hold<=load_data, hold_full<=1. load_ready then falls the next cycle.
- done is registered: high exactly one cycle, the cycle after the last-bit edge. It is 0 at all other times.
- data_out=0 whenever frame=0.
- Latency:
  - From IDLE, the first bit appears on data_out the cycle after acceptance.
  - With enable held at 1, a word occupies exactly WIDTH cycles of frame.
- Simultaneous events:
  - reset has priority over everything.
  - A last-bit edge with hold_full also clears hold_full that edge. load_ready was 0, so no new acceptance can occur that edge.
- Counter wrap: cnt never exceeds WIDTH-1; it is reset to 0 on every load into sreg.

Test Plan:
- WIDTH=4, MSB_FIRST=1, accept 4'b1011, enable=1 throughout -> data_out 1,0,1,1 on cycles 1-4 after accept; frame=1 on cycles 1-4; done=1 on cycle 5 only; frame=0 and load_ready=1 from cycle 5.
- Same word with enable pattern 1,0,0,1,1,1 -> each bit is held for the disabled cycles: data_out = 1,0,0,0,1,1. frame covers 6 cycles; done is asserted the cycle after the sixth.
- Back-to-back: accept 4'b1100, then 4'b0110 one cycle later, enable=1 -> load_ready=0 while the second word is held; data_out 1,1,0,0,0,1,1,0 with no frame gap; two done pulses 4 cycles apart.
- Last-bit bypass: hold empty, load_valid asserted exactly on the last-bit edge of the current word -> the new word starts the next cycle with frame continuous and hold_full never set.
- Reset mid-word: assert reset after 2 bits of 4'b1111, with a second word held -> next cycle data_out=0, frame=0, busy=0, load_ready=1; no done pulse; the held word is never transmitted.
- MSB_FIRST=0, WIDTH=8, accept 8'hA5 -> data_out 1,0,1,0,0,1,0,1 (LSB first); done pulses after 8 enabled cycles.
